// File: rtl/exu_mem_stage_pkg.sv
// exu_mem_stage_pkg: shared core defines for the memory stage (sizes, FSM states, width defaults).
package exu_mem_stage_pkg;
  localparam int XLEN_DEF        = 32;
  localparam int ADDR_WIDTH_DEF  = 32;
  localparam int RFIDX_WIDTH_DEF = 5;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_e;
endpackage

// File: rtl/exu_mem_stage_ld_align.sv
// exu_ld_align: picks the addressed lane out of a load response and sign/zero-extends it.
module exu_ld_align
  import exu_mem_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int LG   = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [LG-1:0]   lane,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data
);
  logic [XLEN-1:0] s, m;
  logic            sign;
  assign s    = rdata >> {lane, 3'b000};
  assign m    = size == SZ_B ? XLEN'(8'hff) : size == SZ_H ? XLEN'(16'hffff) :
                (size == SZ_W && XLEN > 32) ? XLEN'(32'hffff_ffff) : '1;
  assign sign = size == SZ_B ? s[7] : size == SZ_H ? s[15] : s[31];
  assign data = (s & m) | ({XLEN{sign & ~is_unsigned}} & ~m);
endmodule

// File: rtl/exu_mem_stage.sv
// exu_mem_stage: single-outstanding load/store issue stage with writeback.
// Optional EXU_MISALIGN_TRAP_EN: trap misaligned ops instead of forcing alignment.
module exu_mem_stage
  import exu_mem_stage_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int RFIDX_WIDTH = RFIDX_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_op_vld,
  output logic                   o_op_rdy,
  input  logic                   i_op_wr,
  input  logic [1:0]             i_op_size,
  input  logic                   i_op_unsigned,
  input  logic [XLEN-1:0]        i_base,
  input  logic [XLEN-1:0]        i_offset,
  input  logic [XLEN-1:0]        i_wdata,
  input  logic [RFIDX_WIDTH-1:0] i_rdidx,
  output logic [ADDR_WIDTH-1:0]  o_lsu_addr,
  output logic                   o_lsu_addr_vld,
  input  logic                   i_lsu_addr_rdy,
  output logic                   o_lsu_wr,
  output logic [XLEN-1:0]        o_lsu_wdata,
  output logic [XLEN/8-1:0]      o_lsu_wstrb,
  input  logic                   i_lsu_rsp_vld,
  input  logic [XLEN-1:0]        i_lsu_rdata,
  output logic                   o_wb_vld,
  output logic [RFIDX_WIDTH-1:0] o_wb_rdidx,
  output logic [XLEN-1:0]        o_wb_data,
  output logic                   o_pipe_stall,
  output logic                   o_misalign
);
  localparam int NB = XLEN / 8;
  localparam int LG = $clog2(NB);
  state_e                 state, nxt;
  logic                   acc, mis, op_wr, op_uns, kill, rsp_ld;
  logic [1:0]             eff, op_size;
  logic [7:0]             ones;
  logic [XLEN-1:0]        sum, rep, ld_data;
  logic [ADDR_WIDTH-1:0]  addr_raw, mask, addr_al;
  logic [NB-1:0]          strb;
  logic [RFIDX_WIDTH-1:0] op_rdidx;
  assign o_op_rdy       = state == IDLE && !i_flush;
  assign acc            = i_op_vld && o_op_rdy;
  assign o_pipe_stall   = state != IDLE;
  assign o_lsu_addr_vld = state == REQ;
  assign o_lsu_wr       = op_wr;
  assign rsp_ld         = state == RSP && i_lsu_rsp_vld && !op_wr;
  assign sum            = i_base + i_offset;
  assign addr_raw       = sum[ADDR_WIDTH-1:0];
  assign eff            = i_op_size > 2'(LG) ? 2'(LG) : i_op_size;
  assign mask           = ADDR_WIDTH'((32'd1 << eff) - 32'd1);
  assign addr_al        = addr_raw & ~mask;
  assign ones           = eff == 2'd0 ? 8'h01 : eff == 2'd1 ? 8'h03 : eff == 2'd2 ? 8'h0f : 8'hff;
  assign strb           = NB'(ones) << addr_al[LG-1:0];
  always_comb begin
    rep = '0;
    for (int j = 0; j < NB; j++) rep[8*j +: 8] = i_wdata[8*(j & ((1 << eff) - 1)) +: 8];
  end
`ifdef EXU_MISALIGN_TRAP_EN
  logic misalign;
  assign mis        = |(addr_raw & mask);
  assign o_misalign = misalign;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) misalign <= 1'b0;
    else misalign <= acc && mis;
`else
  assign mis        = 1'b0;
  assign o_misalign = 1'b0;
`endif
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (acc && !mis ? REQ : IDLE) :
          state == REQ  ? (i_lsu_addr_rdy ? RSP : REQ) :
                          (i_lsu_rsp_vld ? IDLE : RSP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  exu_ld_align #(.XLEN(XLEN), .LG(LG)) u_ld_align (
    .rdata(i_lsu_rdata), .lane(o_lsu_addr[LG-1:0]), .size(op_size),
    .is_unsigned(op_uns), .data(ld_data)
  );
  // kill only lives between acceptance and the return to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_lsu_addr  <= '0;
      o_lsu_wdata <= '0;
      o_lsu_wstrb <= '0;
      o_wb_vld    <= 1'b0;
      o_wb_data   <= '0;
      o_wb_rdidx  <= '0;
      op_wr       <= 1'b0;
      op_uns      <= 1'b0;
      op_size     <= '0;
      op_rdidx    <= '0;
      kill        <= 1'b0;
    end else begin
      o_wb_vld <= rsp_ld && !kill && !i_flush;
      kill     <= state != IDLE && (kill || i_flush);
      if (acc) begin
        o_lsu_addr  <= addr_al;
        o_lsu_wdata <= rep;
        o_lsu_wstrb <= i_op_wr ? strb : '0;
        op_wr       <= i_op_wr;
        op_uns      <= i_op_unsigned;
        op_size     <= eff;
        op_rdidx    <= i_rdidx;
      end
      if (rsp_ld) begin
        o_wb_data  <= ld_data;
        o_wb_rdidx <= op_rdidx;
      end
    end
  end
endmodule

// File: tb/tb_exu_mem_stage.sv
// tb_exu_mem_stage: directed table, hand corner sequences and random ops against a reference model.
module tb_exu_mem_stage;
  logic        clk = 0, rst_n = 0;
  logic        flush = 0, op_vld = 0, op_rdy, op_wr = 0, op_uns = 0;
  logic [1:0]  op_size = 0;
  logic [31:0] base = 0, offset = 0, wdata = 0, lsu_addr, lsu_wdata, lsu_rdata = 0, wb_data;
  logic [4:0]  rdidx = 0, wb_rdidx;
  logic        addr_vld, addr_rdy = 0, lsu_wr, rsp_vld = 0, wb_vld, stall, misalign;
  logic [3:0]  wstrb;
  int          passed = 0, total = 0;

  typedef struct {
    logic wr; logic [1:0] size; logic uns;
    logic [31:0] base, off, wdata; logic [4:0] rdidx; logic [31:0] rdata;
    logic [31:0] addr; logic [3:0] wstrb; logic [31:0] xwdata, data;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  exu_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_op_vld(op_vld), .o_op_rdy(op_rdy),
    .i_op_wr(op_wr), .i_op_size(op_size), .i_op_unsigned(op_uns), .i_base(base),
    .i_offset(offset), .i_wdata(wdata), .i_rdidx(rdidx), .o_lsu_addr(lsu_addr),
    .o_lsu_addr_vld(addr_vld), .i_lsu_addr_rdy(addr_rdy), .o_lsu_wr(lsu_wr),
    .o_lsu_wdata(lsu_wdata), .o_lsu_wstrb(wstrb), .i_lsu_rsp_vld(rsp_vld),
    .i_lsu_rdata(lsu_rdata), .o_wb_vld(wb_vld), .o_wb_rdidx(wb_rdidx), .o_wb_data(wb_data),
    .o_pipe_stall(stall), .o_misalign(misalign)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: byte-granular arithmetic straight from the access rules.
  function automatic vec_t model(input logic wr, input logic [1:0] size, input logic uns,
                                 input logic [31:0] b, input logic [31:0] o, input logic [31:0] wd,
                                 input logic [4:0] rd, input logic [31:0] rdat);
    vec_t v;
    int nb, lane;
    longint val;
    nb = 1 << (size > 2 ? 2 : size);
    v.wr = wr; v.size = size; v.uns = uns; v.base = b; v.off = o; v.wdata = wd;
    v.rdidx = rd; v.rdata = rdat;
    v.addr = (b + o) / nb * nb;
    lane = v.addr % 4;
    v.wstrb = wr ? 4'(((1 << nb) - 1) << lane) : 4'd0;
    for (int j = 0; j < 4; j++) v.xwdata[8*j +: 8] = 8'((wd >> (8 * (j % nb))) & 32'hff);
    val = longint'(rdat) >> (8 * lane);
    if (nb < 4) begin
      val = val % (64'sd1 << (8 * nb));
      if (!uns && val >= (64'sd1 << (8 * nb - 1))) val = val - (64'sd1 << (8 * nb));
    end
    v.data = val[31:0];
    return v;
  endfunction

  task automatic run_op(input vec_t v, input int ad, input bit fl, input bit junk);
    @(negedge clk);
    op_vld = 1; op_wr = v.wr; op_size = v.size; op_uns = v.uns; base = v.base;
    offset = v.off; wdata = v.wdata; rdidx = v.rdidx;
    #1 chk("op_rdy_idle", op_rdy, 1);
    @(posedge clk); #1 op_vld = 0;
    chk("req_addr_vld", addr_vld, 1);
    chk("req_addr", lsu_addr, v.addr);
    chk("req_wstrb", wstrb, v.wstrb);
    chk("req_wr", lsu_wr, v.wr);
    chk("req_stall", stall, 1);
    if (v.wr) chk("req_wdata", lsu_wdata, v.xwdata);
    for (int i = 0; i < ad; i++) begin
      if (junk && i == 0) rsp_vld = 1;
      @(posedge clk); #1 rsp_vld = 0;
      chk("hold_addr_vld", addr_vld, 1);
      chk("hold_addr", lsu_addr, v.addr);
      chk("hold_wstrb", wstrb, v.wstrb);
      chk("hold_stall", stall, 1);
      if (v.wr) chk("hold_wdata", lsu_wdata, v.xwdata);
    end
    addr_rdy = 1;
    @(posedge clk); #1 addr_rdy = 0;
    chk("rsp_addr_vld", addr_vld, 0);
    chk("rsp_stall", stall, 1);
    chk("rsp_op_rdy", op_rdy, 0);
    if (fl) begin
      flush = 1;
      @(posedge clk); #1 flush = 0;
      chk("flush_stall", stall, 1);
    end
    rsp_vld = 1; lsu_rdata = v.rdata;
    @(posedge clk); #1 rsp_vld = 0;
    chk("wb_vld", wb_vld, !v.wr && !fl);
    if (!v.wr && !fl) begin
      chk("wb_data", wb_data, v.data);
      chk("wb_rdidx", wb_rdidx, v.rdidx);
    end
    chk("done_stall", stall, 0);
    @(posedge clk); #1 chk("wb_pulse", wb_vld, 0);
  endtask

  initial begin
    tbl[0] = model(0, 2, 0, 32'h100, 32'h4, 32'h0, 5'd7, 32'hDEADBEEF);
    tbl[1] = model(0, 0, 0, 32'h100, 32'h3, 32'h0, 5'd3, 32'h80000000);
    tbl[2] = model(0, 0, 1, 32'h100, 32'h3, 32'h0, 5'd4, 32'h80000000);
    tbl[3] = model(1, 1, 0, 32'h200, 32'h2, 32'h1234ABCD, 5'd0, 32'h0);
    tbl[4] = model(1, 0, 0, 32'h300, 32'h1, 32'h00000055, 5'd0, 32'h0);
    tbl[5] = model(0, 1, 0, 32'h0, 32'h2, 32'h0, 5'd9, 32'h7FFF0000);
    tbl[6] = model(0, 3, 0, 32'h10, 32'h0, 32'h0, 5'd31, 32'h12345678);
    // spot-check the reference against hand values before trusting it
    chk("ref_ld_word", tbl[0].data, 32'hDEADBEEF);
    chk("ref_ld_addr", tbl[0].addr, 32'h104);
    chk("ref_ld_sbyte", tbl[1].data, 32'hFFFFFF80);
    chk("ref_ld_ubyte", tbl[2].data, 32'h00000080);
    chk("ref_st_strb", tbl[3].wstrb, 4'b1100);
    chk("ref_st_wdata", tbl[3].xwdata, 32'hABCDABCD);
    #12;
    chk("rst_addr_vld", addr_vld, 0);
    chk("rst_wb_vld", wb_vld, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_stall", stall, 0);
    chk("rst_addr", lsu_addr, 0);
    chk("rst_wdata", lsu_wdata, 0);
    chk("rst_wstrb", wstrb, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rdidx", wb_rdidx, 0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 7; i++) run_op(tbl[i], i == 3 ? 5 : 0, 0, 0);
    run_op(tbl[0], 5, 0, 1);
    run_op(tbl[0], 1, 1, 0);
    @(negedge clk); flush = 1; op_vld = 1;
    #1 chk("flush_idle_rdy", op_rdy, 0);
    @(posedge clk); #1 flush = 0; op_vld = 0;
    chk("flush_idle_stall", stall, 0);
    chk("flush_idle_vld", addr_vld, 0);
`ifdef EXU_MISALIGN_TRAP_EN
    @(negedge clk); op_vld = 1; op_wr = 0; op_size = 2; base = 32'h101; offset = 0;
    #1 chk("mis_rdy", op_rdy, 1);
    @(posedge clk); #1 op_vld = 0;
    chk("mis_pulse", misalign, 1);
    chk("mis_addr_vld", addr_vld, 0);
    chk("mis_stall", stall, 0);
    @(posedge clk); #1 chk("mis_pulse_end", misalign, 0);
    chk("mis_addr_vld2", addr_vld, 0);
`else
    run_op(model(0, 2, 0, 32'h101, 32'h0, 32'h0, 5'd5, 32'hCAFEF00D), 0, 0, 0);
    chk("ref_align", tbl[0].addr - 32'h4, 32'h100);
`endif
    @(negedge clk); op_vld = 1; op_wr = 0; op_size = 2; base = 32'h40; offset = 0; rdidx = 2;
    @(posedge clk); #1 op_vld = 0;
    rst_n = 0;
    #1 chk("midrst_vld", addr_vld, 0);
    chk("midrst_stall", stall, 0);
    @(negedge clk) rst_n = 1;
    rsp_vld = 1;
    @(posedge clk); #1 rsp_vld = 0;
    chk("midrst_wb", wb_vld, 0);
    @(posedge clk); #1 chk("midrst_wb2", wb_vld, 0);
    chk("midrst_stall2", stall, 0);
    for (int i = 0; i < 40; i++) begin
      int ad;
      ad = $urandom_range(0, 3);
      run_op(model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom(), $urandom(), $urandom(), 5'($urandom_range(0, 31)), $urandom()),
             ad, $urandom_range(0, 7) == 0, ad > 0 && $urandom_range(0, 1) == 1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
